// File: rtl/i2s_tx.sv
// I2S transmitter: mono PCM sample duplicated onto left and right channels of a 64-slot frame.
// One-deep holding buffer in front of the frame shift source; underrun flags an empty buffer.
module i2s_tx #(
   parameter int unsigned WD       = 24,
   parameter int unsigned BCLK_DIV = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
   input  logic [WD-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          bclk,
   output logic          lrck,
   output logic          sdata,
   output logic          underrun,
   output logic          busy
);

   localparam int unsigned DivW = $clog2(BCLK_DIV);
   localparam logic [DivW-1:0] DivMax = DivW'(BCLK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e          state_q, state_d;
   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic            bclk_q, bclk_d;
   logic [5:0]      bit_cnt_q, bit_cnt_d;
   logic            lrck_q, lrck_d;
   logic            sdata_q, sdata_d;
   logic [WD-1:0]   frame_q, frame_d;
   logic [WD-1:0]   buffer_q, buffer_d;
   logic            buf_full_q, buf_full_d;
   logic            s_ready_q;
   logic            underrun_q, underrun_d;
   logic            tick, fall, wrap;

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      bclk_d     = bclk_q;
      bit_cnt_d  = bit_cnt_q;
      lrck_d     = lrck_q;
      sdata_d    = sdata_q;
      frame_d    = frame_q;
      buffer_d   = buffer_q;
      buf_full_d = buf_full_q;
      underrun_d = 1'b0;

      tick = (state_q != StIdle) && (div_cnt_q == DivMax);
      fall = tick && bclk_q;
      wrap = fall && (bit_cnt_q == 6'd63);

      case (state_q)
         StIdle:  if (en) state_d = StRun;
         StRun:   if (!en) state_d = StDrain;
         StDrain: begin
            if (en) begin
               state_d = StRun;
            end else if (wrap) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_q != StIdle) begin
         if (tick) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
         if (fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrck_d    = bit_cnt_d[5];
            // Slot 0 of each channel stays low: the one-bit I2S delay before the MSB.
            sdata_d   = 1'b0;
            for (int unsigned i = 1; i <= WD && i < 32; i++) begin
               if (bit_cnt_d[4:0] == 5'(i)) sdata_d = frame_q[WD-i];
            end
         end
         // Frames load only when the FSM keeps running past the wrap.
         if (wrap && (state_d != StIdle)) begin
            if (buf_full_q) begin
               frame_d    = buffer_q;
               buf_full_d = 1'b0;
            end else begin
               frame_d    = '0;
               underrun_d = 1'b1;
            end
         end
      end

      if (state_d == StIdle) begin
         div_cnt_d = '0;
         bclk_d    = 1'b0;
         lrck_d    = 1'b0;
         sdata_d   = 1'b0;
         bit_cnt_d = 6'd63;
      end

      // A sample arriving on an empty-buffer load edge is kept for the next frame.
      if (s_valid && s_ready_q) begin
         buffer_d   = s_data;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         div_cnt_q  <= '0;
         bclk_q     <= 1'b0;
         bit_cnt_q  <= 6'd63;
         lrck_q     <= 1'b0;
         sdata_q    <= 1'b0;
         frame_q    <= '0;
         buffer_q   <= '0;
         buf_full_q <= 1'b0;
         s_ready_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         bclk_q     <= bclk_d;
         bit_cnt_q  <= bit_cnt_d;
         lrck_q     <= lrck_d;
         sdata_q    <= sdata_d;
         frame_q    <= frame_d;
         buffer_q   <= buffer_d;
         buf_full_q <= buf_full_d;
         s_ready_q  <= ~buf_full_d;
         underrun_q <= underrun_d;
      end
   end

   assign s_ready  = s_ready_q;
   assign bclk     = bclk_q;
   assign lrck     = lrck_q;
   assign sdata    = sdata_q;
   assign underrun = underrun_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter WD, default 24: sample width in bits, matching the FIR output width.
REQ-002 Parameter BCLK_DIV, default 4: BCLK half-period in clk cycles; legal range is 2 or more; BCLK = clk/(2*BCLK_DIV).
REQ-003 clk  input  1  system clock (100 MHz); all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 en  input  1  transmit enable.
REQ-006 s_data  input  WD  signed PCM sample from FIR data_out.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  block can accept a sample.
REQ-009 bclk  output  1  I2S bit clock.
REQ-010 lrck  output  1  I2S word select; 0 = left, 1 = right.
REQ-011 sdata  output  1  I2S serial data, MSB first.
REQ-012 underrun  output  1  one-clk pulse when a frame starts with no sample buffered.
REQ-013 busy  output  1  high when the FSM is not IDLE.

Function
REQ-014 Format is mono-to-stereo: each 64-BCLK frame (32 slots per channel) consumes one sample and transmits it on both L and R.
REQ-015 Buffer is one holding register plus buf_full flag; s_ready = !buf_full, registered, with no same-cycle bypass.
REQ-016 A transfer occurs when s_valid and s_ready are both high: buffer <= s_data and buf_full <= 1; s_valid while buf_full is ignored.
REQ-017 FSM states are IDLE, RUN and DRAIN.
REQ-018 IDLE -> RUN when en = 1.
REQ-019 RUN -> DRAIN when en = 0.
REQ-020 DRAIN -> RUN when en = 1, with no frame break.
REQ-021 DRAIN -> IDLE at the falling-edge event where bit_cnt wraps 63 -> 0; no load occurs on that event.
REQ-022 In IDLE: div_cnt = 0, bclk = 0, lrck = 0, sdata = 0, bit_cnt = 63; buffer contents are retained.
REQ-023 In RUN and DRAIN, div_cnt counts 0..BCLK_DIV-1 and bclk toggles on the cycle where div_cnt = BCLK_DIV-1.
REQ-024 A falling-edge event is a bclk toggle from 1 to 0; on that same clk edge, bit_cnt increments mod 64, and lrck and sdata update to the new slot's values.
REQ-025 lrck = new bit_cnt[5].
REQ-026 sdata for slot i = new bit_cnt[4:0] is frame[WD-i] for i = 1..WD, otherwise 0; slot 0 is the I2S one-bit delay.
REQ-027 Frame load occurs at the falling-edge event where bit_cnt wraps 63 -> 0 in RUN: if buf_full, frame <= buffer and buf_full <= 0 in that cycle; otherwise frame <= 0 and underrun pulses for that one cycle.
REQ-028 A transfer in the same cycle as a frame load with an empty buffer does not reach that frame, which is an underrun; the sample is kept for the next frame.
REQ-029 A transfer in the same cycle as a load from a full buffer cannot occur, because s_ready was 0.
REQ-030 The first frame after IDLE -> RUN loads at the first falling-edge event, 2*BCLK_DIV clks after entering RUN.
REQ-031 Latency: the MSB of a buffered sample appears on sdata one BCLK period (2*BCLK_DIV clks) after its load.
REQ-032 Frame length is 128*BCLK_DIV clks.

Reset
REQ-033 While reset_n = 0 at a rising clk edge, the block goes to IDLE, clears buf_full, buffer, frame, div_cnt and underrun, sets bit_cnt = 63, and drives s_ready = 0, bclk = 0, lrck = 0, sdata = 0, busy = 0.
REQ-034 s_ready rises on the first clk edge after reset_n = 1.
REQ-035 Reset mid-frame aborts immediately, with no drain.

Verification (BCLK_DIV = 2, WD = 24)
REQ-036 Reset, then s_data = 24'hA55A3C with valid, en = 1 -> bclk period 4 clks; first frame loads at clk 4 of RUN; sdata slots 1..24 of both L and R = 1010_0101_0101_1010_0011_1100; other slots 0; lrck low for 32 BCLK, then high for 32.
REQ-037 en = 1 with no sample supplied -> underrun pulses once per 256 clks and sdata stays 0.
REQ-038 Continuous samples 24'h000001, 24'h800000 and 24'h7FFFFF, each supplied on s_ready -> no underrun; LSB in slot 24 for 24'h000001; MSB only for 24'h800000; slots 1..24 = 0 then 1 for 24'h7FFFFF.
REQ-039 en dropped at BCLK 10 of a frame -> frame completes all 64 BCLKs; then bclk, lrck and sdata = 0 and busy = 0; held sample is transmitted first after en is re-asserted.
REQ-040 s_valid asserted on the exact load cycle with an empty buffer -> underrun pulse; the sample appears in the following frame.
REQ-041 reset_n = 0 mid-frame at slot 12 -> all outputs 0 on the next clk edge; s_ready = 1 one clk after release.
